// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
//   Handshake/bus bundle between NUM_REQ producers, the write arbiter and the
//   FIFO write port.
//   req_valid/req_data/req_ready : per-producer valid/ready beat interface
//   w_en/data_in/full            : FIFO write side
//   grant_vld/grant_id           : current ownership status
//   modport slave  : the arbiter
//   modport master : the producers/FIFO side driving it
interface fifo_wr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4
) ();
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic                          full;
    logic                          grant_vld;
    logic [ID_W-1:0]               grant_id;

    modport slave (
        input  req_valid, req_data, full,
        output req_ready, w_en, data_in, grant_vld, grant_id
    );

    modport master (
        output req_valid, req_data, full,
        input  req_ready, w_en, data_in, grant_vld, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
//   A grant is held for up to MAX_BURST accepted beats, or until the owner
//   drops valid; FIFO full stalls the owner without counting toward the burst.
//   Ports:
//     clk   : clock, all state on posedge
//     rst_n : asynchronous active-low reset
//     bus   : fifo_wr_arbiter_if.slave (req_valid/req_data/req_ready,
//             w_en/data_in/full, grant_vld/grant_id)
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       owner;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  grant_q;

    logic                  sel_found;
    logic [ID_W-1:0]       sel_idx;
    logic                  own_valid;
    logic [DATA_WIDTH-1:0] own_data;

    // Round-robin pick as two linear passes (indices >= rr_ptr first, then
    // the ones below it) so every select index is a loop constant.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!sel_found && bus.req_valid[i] && (i >= 32'(rr_ptr))) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!sel_found && bus.req_valid[i] && (i < 32'(rr_ptr))) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(i);
            end
        end
    end

    always_comb begin
        own_valid = 1'b0;
        own_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (i == 32'(owner)) begin
                own_valid = bus.req_valid[i];
                own_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Write side follows the owner combinationally; gated by state so an
    // asynchronous reset kills w_en immediately.
    always_comb begin
        bus.req_ready = '0;
        bus.w_en      = 1'b0;
        bus.data_in   = '0;
        if (state == LOCKED) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (i == 32'(owner)) begin
                    bus.req_ready[i] = !bus.full;
                end
            end
            bus.w_en    = own_valid & !bus.full;
            bus.data_in = own_data;
        end
    end

    assign bus.grant_vld = grant_q;
    assign bus.grant_id  = owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            grant_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        owner    <= sel_idx;
                        beat_cnt <= '0;
                        grant_q  <= 1'b1;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Release on owner drop (even while full) or on the last
                    // accepted beat of the burst; a full stall just holds.
                    if (!own_valid || (!bus.full && (beat_cnt == LAST_BEAT))) begin
                        rr_ptr  <= (owner == LAST_ID) ? '0 : owner + 1'b1;
                        grant_q <= 1'b0;
                        state   <= IDLE;
                    end else if (!bus.full) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4, 8-bit data).
//   Producers are modelled by per-requester base+count data; every FIFO write
//   is logged with the grant id for order/content checks.
module tb_fifo_wr_arbiter;
    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [NR-1:0] valid_r;
    logic [7:0]    base [NR];
    logic [7:0]    cnt  [NR];
    logic [7:0]    wq  [$];
    logic [1:0]    wid [$];
    logic          ovf = 1'b0;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.w_en === 1'b1) begin
            wq.push_back(bus.data_in);
            wid.push_back(bus.grant_id);
            if (bus.full !== 1'b0) ovf = 1'b1;
        end
    end

    task automatic drive();
        bus.req_valid = valid_r;
        for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = base[i] + cnt[i];
    endtask

    // Called at a negedge: advance across the next posedge, bumping the
    // counters of producers whose beat was accepted at that edge.
    task automatic adv();
        logic [NR-1:0] acc;
        acc = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (acc[i]) cnt[i] = cnt[i] + 8'd1;
        drive();
    endtask

    task automatic cyc();
        @(negedge clk);
        adv();
    endtask

    task automatic clear_stim();
        valid_r  = '0;
        bus.full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            cnt[i]  = 8'd0;
            base[i] = 8'd0;
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_stim();
        cyc();
        cyc();
        rst_n = 1'b1;
        wq.delete();
        wid.delete();
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        clear_stim();
        for (int i = 0; i < 3; i++) cyc();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant_vld !== 1'b0) begin errors++; $display("FAIL rst_grant_vld: got %b expected 0", bus.grant_vld); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: got %0d expected 0", bus.grant_id); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.w_en !== 1'b0) begin errors++; $display("FAIL rst_w_en: got %b expected 0", bus.w_en); end
        checks++; if (bus.data_in !== 8'h00) begin errors++; $display("FAIL rst_data_in: got %h expected 00", bus.data_in); end
        adv();
        base[1] = 8'h30;
        valid_r = 4'b0010;
        drive();
        cyc();
        @(negedge clk);
        checks++; if (bus.grant_vld !== 1'b1 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL midrst_grant: got vld=%b id=%0d expected vld=1 id=1", bus.grant_vld, bus.grant_id); end
        checks++; if (bus.w_en !== 1'b1) begin errors++; $display("FAIL midrst_w_en_before: got %b expected 1", bus.w_en); end
        adv();
        n = wq.size();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.w_en !== 1'b0) begin errors++; $display("FAIL midrst_w_en_async: got %b expected 0", bus.w_en); end
        checks++; if (bus.grant_vld !== 1'b0) begin errors++; $display("FAIL midrst_grant_async: got %b expected 0", bus.grant_vld); end
        cyc();
        cyc();
        checks++; if (wq.size() != n) begin errors++; $display("FAIL midrst_no_write: got %0d writes expected %0d", wq.size(), n); end
        // With rr_ptr back at 0, req 0 must win over req 2.
        valid_r = 4'b0101;
        drive();
        rst_n = 1'b1;
        cyc();
        @(negedge clk);
        checks++; if (bus.grant_vld !== 1'b1 || bus.grant_id !== 2'd0) begin errors++; $display("FAIL midrst_rr_ptr: got vld=%b id=%0d expected vld=1 id=0", bus.grant_vld, bus.grant_id); end
        valid_r = '0;
        drive();
        adv();
        cyc();
        cyc();
    endtask

    task automatic test_single();
        logic [10:0] pat;
        logic [7:0]  ed;
        do_reset();
        base[2] = 8'h10;
        valid_r = 4'b0100;
        drive();
        pat = 11'b01111011110;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            ed = pat[k] ? 8'(16 + ((k < 5) ? k - 1 : k - 2)) : 8'h00;
            checks++; if (bus.grant_vld !== pat[k]) begin errors++; $display("FAIL single_grant_vld[%0d]: got %b expected %b", k, bus.grant_vld, pat[k]); end
            checks++; if (bus.w_en !== pat[k]) begin errors++; $display("FAIL single_w_en[%0d]: got %b expected %b", k, bus.w_en, pat[k]); end
            checks++; if (bus.data_in !== ed) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", k, bus.data_in, ed); end
            if (pat[k]) begin
                checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id[%0d]: got %0d expected 2", k, bus.grant_id); end
            end
            if (k == 10) begin
                valid_r = '0;
                drive();
            end
            adv();
        end
        checks++; if (wq.size() != 8) begin errors++; $display("FAIL single_count: got %0d expected 8", wq.size()); end
        for (int j = 0; j < 8 && j < wq.size(); j++) begin
            checks++; if (wq[j] !== 8'(16 + j)) begin errors++; $display("FAIL single_fifo[%0d]: got %h expected %h", j, wq[j], 8'(16 + j)); end
        end
    endtask

    task automatic test_all();
        int guard;
        logic [1:0] eid;
        logic [7:0] ed;
        do_reset();
        for (int i = 0; i < NR; i++) base[i] = 8'(i * 64);
        valid_r = 4'b1111;
        drive();
        guard = 0;
        while (wq.size() < 20 && guard < 60) begin
            @(negedge clk);
            checks++; if ($countones(bus.req_ready) > 1) begin errors++; $display("FAIL all_ready_onehot: got %b expected at most one bit", bus.req_ready); end
            adv();
            guard++;
        end
        valid_r = '0;
        drive();
        checks++; if (wq.size() != 20) begin errors++; $display("FAIL all_count: got %0d expected 20", wq.size()); end
        checks++; if (guard != 25) begin errors++; $display("FAIL all_cycles: got %0d expected 25", guard); end
        for (int j = 0; j < 20 && j < wq.size(); j++) begin
            eid = 2'((j / 4) % 4);
            ed  = 8'(eid * 64 + (j / 16) * 4 + (j % 4));
            checks++; if (wid[j] !== eid) begin errors++; $display("FAIL all_order[%0d]: got id %0d expected %0d", j, wid[j], eid); end
            checks++; if (wq[j] !== ed) begin errors++; $display("FAIL all_fifo[%0d]: got %h expected %h", j, wq[j], ed); end
        end
        cyc();
        cyc();
    endtask

    task automatic test_backpressure();
        do_reset();
        base[1] = 8'h50;
        valid_r = 4'b0010;
        drive();
        for (int k = 0; k < 9; k++) begin
            bus.full = (k >= 3 && k <= 5);
            @(negedge clk);
            if (k >= 3 && k <= 5) begin
                checks++; if (bus.w_en !== 1'b0) begin errors++; $display("FAIL bp_w_en[%0d]: got %b expected 0", k, bus.w_en); end
                checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, bus.req_ready); end
                checks++; if (bus.grant_vld !== 1'b1 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL bp_grant[%0d]: got vld=%b id=%0d expected vld=1 id=1", k, bus.grant_vld, bus.grant_id); end
            end
            if (k == 6 || k == 7) begin
                checks++; if (bus.w_en !== 1'b1 || bus.data_in !== 8'(8'h50 + k - 4)) begin errors++; $display("FAIL bp_resume[%0d]: got w_en=%b data=%h expected w_en=1 data=%h", k, bus.w_en, bus.data_in, 8'(8'h50 + k - 4)); end
            end
            if (k == 8) begin
                checks++; if (bus.grant_vld !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", bus.grant_vld); end
                valid_r = '0;
                drive();
            end
            adv();
        end
        checks++; if (wq.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", wq.size()); end
        for (int j = 0; j < 4 && j < wq.size(); j++) begin
            checks++; if (wq[j] !== 8'(8'h50 + j)) begin errors++; $display("FAIL bp_fifo[%0d]: got %h expected %h", j, wq[j], 8'(8'h50 + j)); end
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        base[1] = 8'h60;
        base[2] = 8'h70;
        base[3] = 8'hA0;
        valid_r = 4'b1000;
        for (int k = 0; k < 7; k++) begin
            if (k == 1) valid_r = 4'b1110;
            if (k == 3) valid_r = 4'b0110;
            drive();
            @(negedge clk);
            if (k == 3) begin
                checks++; if (bus.grant_vld !== 1'b1 || bus.grant_id !== 2'd3) begin errors++; $display("FAIL drop_hold: got vld=%b id=%0d expected vld=1 id=3", bus.grant_vld, bus.grant_id); end
                checks++; if (bus.w_en !== 1'b0) begin errors++; $display("FAIL drop_w_en: got %b expected 0", bus.w_en); end
            end
            if (k == 4) begin
                checks++; if (bus.grant_vld !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b expected 0", bus.grant_vld); end
            end
            if (k == 5) begin
                checks++; if (bus.grant_vld !== 1'b1 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL drop_next_grant: got vld=%b id=%0d expected vld=1 id=1", bus.grant_vld, bus.grant_id); end
                valid_r = '0;
                drive();
            end
            adv();
        end
        checks++; if (wq.size() != 2) begin errors++; $display("FAIL drop_count: got %0d expected 2", wq.size()); end
        for (int j = 0; j < 2 && j < wq.size(); j++) begin
            checks++; if (wq[j] !== 8'(8'hA0 + j) || wid[j] !== 2'd3) begin errors++; $display("FAIL drop_fifo[%0d]: got %h id %0d expected %h id 3", j, wq[j], wid[j], 8'(8'hA0 + j)); end
        end
    endtask

    task automatic test_wrap();
        int guard;
        int exp_cnt [NR];
        logic [1:0] eid;
        do_reset();
        base[0] = 8'h20;
        base[2] = 8'h70;
        base[3] = 8'hB0;
        // Grant req 2 and drop before any beat: leaves rr_ptr at 3.
        valid_r = 4'b0100;
        drive();
        cyc();
        @(negedge clk);
        valid_r = '0;
        drive();
        adv();
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL wrap_zero_beat: got %0d writes expected 0", wq.size()); end
        checks++; if (bus.grant_vld !== 1'b0) begin errors++; $display("FAIL wrap_setup_release: got %b expected 0", bus.grant_vld); end
        valid_r = 4'b1001;
        drive();
        guard = 0;
        while (wq.size() < 16 && guard < 50) begin
            cyc();
            guard++;
        end
        valid_r = '0;
        drive();
        checks++; if (wq.size() != 16) begin errors++; $display("FAIL wrap_count: got %0d expected 16", wq.size()); end
        for (int i = 0; i < NR; i++) exp_cnt[i] = 0;
        for (int j = 0; j < 16 && j < wq.size(); j++) begin
            eid = ((j / 4) % 2 == 0) ? 2'd3 : 2'd0;
            checks++; if (wid[j] !== eid) begin errors++; $display("FAIL wrap_order[%0d]: got id %0d expected %0d", j, wid[j], eid); end
            checks++; if (wq[j] !== 8'(base[eid] + exp_cnt[eid])) begin errors++; $display("FAIL wrap_fifo[%0d]: got %h expected %h", j, wq[j], 8'(base[eid] + exp_cnt[eid])); end
            exp_cnt[eid]++;
        end
        checks++; if (int'(cnt[0]) != 8 || int'(cnt[3]) != 8) begin errors++; $display("FAIL wrap_accepts: got req0=%0d req3=%0d expected 8 and 8", cnt[0], cnt[3]); end
        checks++; if (exp_cnt[0] != int'(cnt[0]) || exp_cnt[3] != int'(cnt[3])) begin errors++; $display("FAIL wrap_lost_dup: got written req0=%0d req3=%0d expected accepted %0d and %0d", exp_cnt[0], exp_cnt[3], cnt[0], cnt[3]); end
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all();
        test_backpressure();
        test_early_drop();
        test_wrap();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL overflow: got w_en with full=%b expected 0", ovf); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
